// File: rtl/mul_mant_round_pipe_if.sv
// Stream interface of the FP32 multiplier normalize/round stage: upstream beat
// (sign, exponent sum, raw significand product) in, packed rounding result out.
interface mul_mant_round_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int ESUM_W = 10
);
    logic                   i_valid;
    logic                   o_ready;
    logic                   i_sign;
    logic [ESUM_W-1:0]      i_exp_sum;
    logic [2*MAN_W+1:0]     i_mant_prod;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_sign;
    logic [EXP_W-1:0]       o_exp;
    logic [MAN_W-1:0]       o_mant;
    logic                   o_carry_rounding;
    logic                   o_overflow;
    logic                   o_underflow;

    modport slave (
        input  i_valid, i_sign, i_exp_sum, i_mant_prod, i_ready,
        output o_ready, o_valid, o_sign, o_exp, o_mant,
        output o_carry_rounding, o_overflow, o_underflow
    );

    modport master (
        output i_valid, i_sign, i_exp_sum, i_mant_prod, i_ready,
        input  o_ready, o_valid, o_sign, o_exp, o_mant,
        input  o_carry_rounding, o_overflow, o_underflow
    );
endinterface

// File: rtl/mul_mant_round_pipe.sv
// Two-stage normalize + round-to-nearest-even stage for the FP32 multiplier.
// Stage 1 normalizes the 48-bit product; stage 2 rounds, saturates or flushes.
module mul_mant_round_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int ESUM_W = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    mul_mant_round_pipe_if.slave  bus
);
    localparam int PROD_W = 2 * MAN_W + 2;
    localparam int SIG_W  = MAN_W + 1;
    localparam int E_W    = ESUM_W + 1;

    localparam logic signed [E_W-1:0] E_ONE_C  = E_W'(1);
    localparam logic signed [E_W-1:0] E_ZERO_C = E_W'(0);
    localparam logic signed [E_W-1:0] E_INF_C  = E_W'((1 << EXP_W) - 1);

    // Round-to-nearest-even increment decision from guard/round/sticky and LSB.
    function automatic logic rne_inc(input logic g, input logic r,
                                     input logic s, input logic lsb);
        rne_inc = g & (r | s | lsb);
    endfunction

    // Handshake
    logic s1_valid_r;
    logic s2_valid_r;
    logic s2_adv_s;
    logic s1_adv_s;
    logic accept_s;

    // Stage 1 combinational / registered
    logic [PROD_W-1:0]     prod_s;
    logic signed [E_W-1:0] esum_ext_s;
    logic [SIG_W-1:0]      nrm_m_s;
    logic                  nrm_g_s;
    logic                  nrm_r_s;
    logic                  nrm_st_s;
    logic signed [E_W-1:0] nrm_e_s;
    logic                  nrm_z_s;

    logic                  s1_sign_r;
    logic [SIG_W-1:0]      s1_m_r;
    logic                  s1_g_r;
    logic                  s1_rb_r;
    logic                  s1_st_r;
    logic signed [E_W-1:0] s1_e_r;
    logic                  s1_z_r;

    // Stage 2 combinational / registered outputs
    logic                  round_up_s;
    logic                  carry_s;
    logic [MAN_W-1:0]      frac_s;
    logic signed [E_W-1:0] e2_s;
    logic [EXP_W-1:0]      res_exp_s;
    logic [MAN_W-1:0]      res_mant_s;
    logic                  res_carry_s;
    logic                  res_ovf_s;
    logic                  res_unf_s;

    logic                  o_sign_r;
    logic [EXP_W-1:0]      o_exp_r;
    logic [MAN_W-1:0]      o_mant_r;
    logic                  o_carry_r;
    logic                  o_ovf_r;
    logic                  o_unf_r;

    assign s2_adv_s = ~s2_valid_r | bus.i_ready;
    assign s1_adv_s = ~s1_valid_r | s2_adv_s;
    assign accept_s = bus.i_valid & s1_adv_s;

    assign prod_s     = bus.i_mant_prod;
    assign esum_ext_s = {bus.i_exp_sum[ESUM_W-1], bus.i_exp_sum};

    // Normalize: pick the 24-bit window below the leading one and collect G/R/S.
    always_comb begin
        nrm_m_s  = '0;
        nrm_g_s  = 1'b0;
        nrm_r_s  = 1'b0;
        nrm_st_s = 1'b0;
        nrm_e_s  = esum_ext_s;
        if (prod_s[PROD_W-1]) begin
            nrm_m_s  = prod_s[PROD_W-1 -: SIG_W];
            nrm_g_s  = prod_s[MAN_W];
            nrm_r_s  = prod_s[MAN_W-1];
            nrm_st_s = |prod_s[MAN_W-2:0];
            nrm_e_s  = esum_ext_s + E_ONE_C;
        end else begin
            nrm_m_s  = prod_s[PROD_W-2 -: SIG_W];
            nrm_g_s  = prod_s[MAN_W-1];
            nrm_r_s  = prod_s[MAN_W-2];
            nrm_st_s = |prod_s[MAN_W-3:0];
            nrm_e_s  = esum_ext_s;
        end
        nrm_z_s = (prod_s[PROD_W-1 -: 2] == 2'b00);
    end

    // Stage 1 register: valid follows the handshake, data loads only on accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_m_r     <= '0;
            s1_g_r     <= 1'b0;
            s1_rb_r    <= 1'b0;
            s1_st_r    <= 1'b0;
            s1_e_r     <= '0;
            s1_z_r     <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= bus.i_valid;
            end
            if (accept_s) begin
                s1_sign_r <= bus.i_sign;
                s1_m_r    <= nrm_m_s;
                s1_g_r    <= nrm_g_s;
                s1_rb_r   <= nrm_r_s;
                s1_st_r   <= nrm_st_s;
                s1_e_r    <= nrm_e_s;
                s1_z_r    <= nrm_z_s;
            end
        end
    end

    // Carry out of the 24-bit add only when the significand is all ones;
    // the 23-bit fraction add then wraps to zero on its own.
    assign round_up_s = rne_inc(s1_g_r, s1_rb_r, s1_st_r, s1_m_r[0]);
    assign carry_s    = (&s1_m_r) & round_up_s;
    assign frac_s     = s1_m_r[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, round_up_s};
    assign e2_s       = s1_e_r + {{(E_W-1){1'b0}}, carry_s};

    // Result select: zero beats everything, then overflow, then flush-to-zero.
    always_comb begin
        res_exp_s   = '0;
        res_mant_s  = '0;
        res_carry_s = 1'b0;
        res_ovf_s   = 1'b0;
        res_unf_s   = 1'b0;
        if (s1_z_r) begin
            res_exp_s   = '0;
            res_mant_s  = '0;
        end else if (e2_s >= E_INF_C) begin
            res_exp_s   = '1;
            res_mant_s  = '0;
            res_carry_s = carry_s;
            res_ovf_s   = 1'b1;
        end else if (e2_s <= E_ZERO_C) begin
            res_exp_s   = '0;
            res_mant_s  = '0;
            res_carry_s = carry_s;
            res_unf_s   = 1'b1;
        end else begin
            res_exp_s   = e2_s[EXP_W-1:0];
            res_mant_s  = frac_s;
            res_carry_s = carry_s;
        end
    end

    // Stage 2 register drives the outputs directly; held while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_r <= 1'b0;
            o_sign_r   <= 1'b0;
            o_exp_r    <= '0;
            o_mant_r   <= '0;
            o_carry_r  <= 1'b0;
            o_ovf_r    <= 1'b0;
            o_unf_r    <= 1'b0;
        end else begin
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (s2_adv_s & s1_valid_r) begin
                o_sign_r  <= s1_sign_r;
                o_exp_r   <= res_exp_s;
                o_mant_r  <= res_mant_s;
                o_carry_r <= res_carry_s;
                o_ovf_r   <= res_ovf_s;
                o_unf_r   <= res_unf_s;
            end
        end
    end

    assign bus.o_ready          = s1_adv_s;
    assign bus.o_valid          = s2_valid_r;
    assign bus.o_sign           = o_sign_r;
    assign bus.o_exp            = o_exp_r;
    assign bus.o_mant           = o_mant_r;
    assign bus.o_carry_rounding = o_carry_r;
    assign bus.o_overflow       = o_ovf_r;
    assign bus.o_underflow      = o_unf_r;
endmodule

// File: tb/tb_mul_mant_round_pipe.sv
// Bench for mul_mant_round_pipe: directed beats, a backpressured stream and a
// mid-flight reset, with a reference model feeding an in-order scoreboard.
module tb_mul_mant_round_pipe;
    logic clk;
    logic rst_n;

    mul_mant_round_pipe_if #(.EXP_W(8), .MAN_W(23), .ESUM_W(10)) bus ();

    mul_mant_round_pipe #(.EXP_W(8), .MAN_W(23), .ESUM_W(10)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int in_flight = 0;
    logic [34:0] sb[$];

    logic [34:0] out_word;
    assign out_word = {bus.o_sign, bus.o_exp, bus.o_mant,
                       bus.o_carry_rounding, bus.o_overflow, bus.o_underflow};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: treat the bits below the 24-bit window as a fraction and
    // compare it with one half.
    function automatic logic [34:0] model(input logic sg, input logic [9:0] es_raw,
                                          input logic [47:0] p);
        logic [47:0] n;
        int          e;
        logic [23:0] m;
        logic [23:0] rest;
        logic        up;
        logic [24:0] mr;
        logic [22:0] frac;
        if (p[47:46] == 2'b00) return {sg, 34'd0};
        if (p[47]) begin
            n = p;
            e = int'($signed(es_raw)) + 1;
        end else begin
            n = p << 1;
            e = int'($signed(es_raw));
        end
        m    = n[47:24];
        rest = n[23:0];
        up   = (rest > 24'h800000) || ((rest == 24'h800000) && m[0]);
        mr   = {1'b0, m} + {24'd0, up};
        if (mr[24]) e = e + 1;
        frac = mr[24] ? 23'd0 : mr[22:0];
        if (e >= 255) return {sg, 8'hFF, 23'd0, mr[24], 2'b10};
        if (e <= 0)   return {sg, 8'h00, 23'd0, mr[24], 2'b01};
        return {sg, e[7:0], frac, mr[24], 2'b00};
    endfunction

    // Monitor: scoreboard push on accept, pop/compare on consume, stall hold, o_ready.
    initial begin : monitor
        logic        stall_prev;
        logic [35:0] held;
        logic        acc;
        logic        cons;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                in_flight  = 0;
                stall_prev = 1'b0;
            end else begin
                chk("o_ready", 64'(bus.o_ready), 64'(!((in_flight == 2) && !bus.i_ready)));
                if (stall_prev) chk("stall_hold", 64'({bus.o_valid, out_word}), 64'(held));
                acc  = bus.i_valid && bus.o_ready;
                cons = bus.o_valid && bus.i_ready;
                if (cons) begin
                    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) chk("sb_data", 64'(out_word), 64'(sb.pop_front()));
                    n_out++;
                end
                stall_prev = bus.o_valid && !bus.i_ready;
                held       = {bus.o_valid, out_word};
                in_flight  = in_flight + (acc ? 1 : 0) - (cons ? 1 : 0);
                if (acc) sb.push_back(model(bus.i_sign, bus.i_exp_sum, bus.i_mant_prod));
            end
        end
    end

    task automatic send(input logic sg, input logic [9:0] es, input logic [47:0] p);
        int k;
        bus.i_valid     = 1'b1;
        bus.i_sign      = sg;
        bus.i_exp_sum   = es;
        bus.i_mant_prod = p;
        k = 0;
        @(negedge clk);
        while (!bus.o_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accept_bound", 64'(k < 50), 64'd1);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [34:0] w);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.o_valid && k < 10);
        chk({tag, "_latency"}, 64'(k), 64'd2);
        chk(tag, 64'(out_word), 64'(w));
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int base;
        int k;
        rst_n           = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_ready     = 1'b1;
        bus.i_sign      = 1'b0;
        bus.i_exp_sum   = 10'd0;
        bus.i_mant_prod = 48'd0;
        #1;
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_data", 64'(out_word), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(1'b0, 10'd127, 48'h900000000000);
        expect_out("mul_1p5x1p5", {1'b0, 8'd128, 23'h100000, 3'b000});
        send(1'b0, 10'd127, 48'h7FFFFFC00000);
        expect_out("round_carry", {1'b0, 8'd128, 23'h000000, 3'b100});
        send(1'b0, 10'd127, 48'h400000400000);
        expect_out("tie_even_hold", {1'b0, 8'd127, 23'h000000, 3'b000});
        send(1'b1, 10'd127, 48'h400000C00000);
        expect_out("tie_odd_up", {1'b1, 8'd127, 23'h000002, 3'b000});
        send(1'b0, 10'd254, 48'h800000000000);
        expect_out("overflow", {1'b0, 8'd255, 23'h000000, 3'b010});
        send(1'b1, 10'h3FB, 48'h400000000000);
        expect_out("underflow", {1'b1, 8'd0, 23'h000000, 3'b001});
        send(1'b1, 10'd127, 48'h000000000000);
        expect_out("zero", {1'b1, 8'd0, 23'h000000, 3'b000});
        send(1'b0, 10'd0, 48'h400000000000);
        expect_out("exp_zero_flush", {1'b0, 8'd0, 23'h000000, 3'b001});
        send(1'b0, 10'd0, 48'h800000000000);
        expect_out("exp_one_min", {1'b0, 8'd1, 23'h000000, 3'b000});
        send(1'b0, 10'd253, 48'hFFFFFF800000);
        expect_out("carry_to_inf", {1'b0, 8'd255, 23'h000000, 3'b110});

        // Backpressured stream of six random beats.
        base = n_out;
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    send(1'($urandom), 10'($urandom_range(300, 0) - 20),
                         {2'($urandom_range(3, 1)), 14'($urandom), 32'($urandom)});
                end
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    bus.i_ready = ((c % 4) == 0) || ((c % 4) == 3);
                    @(posedge clk);
                    #1;
                end
                bus.i_ready = 1'b1;
            end
        join
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("bp_drained", 64'(sb.size()), 64'd0);
        chk("bp_count", 64'(n_out - base), 64'd6);

        // Reset with two beats in flight.
        bus.i_ready = 1'b0;
        send(1'b0, 10'd130, 48'hC00000000000);
        send(1'b1, 10'd120, 48'h500000000000);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_o_ready", 64'(bus.o_ready), 64'd1);
        chk("midrst_data", 64'(out_word), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.i_ready = 1'b1;
        base = n_out;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(bus.o_ready), 64'd1);
        chk("post_rst_no_stale", 64'(n_out - base), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
